// File: rtl/usb_fs_packet_receiver.sv
// usb_fs_packet_receiver
//   Golden-reference USB 1.1 full-speed receiver. It oversamples D+/D- at
//   48 MHz, recovers the 12 MHz bit clock, NRZI-decodes, removes stuffed
//   bits, finds SYNC/EOP and decodes PID, token and data packets with CRC
//   checks.
//
//   Optional build macro: USBFS_RX_INSYNC_EN
//     When it is defined, i_dp/i_dn pass through a 2-flop synchronizer, and
//     every output moves 2 cycles later.
//
// Parameters
//   AS_HOST_NOT_DEV : 1 = host instance, so tokens never report okay.
//   MAX_PKT         : largest data payload (bytes) kept in o_lastData.
//
// Ports
//   i_clk_48MHz, i_rst      : clock and synchronous active-high reset.
//   i_dp, i_dn              : bus lines.
//   o_strobe_12MHz          : mid-bit sample pulse.
//   o_sop / o_eop           : SYNC-complete / EOP-complete pulses.
//   o_inflight              : high from o_sop through the o_eop cycle.
//   o_pid                   : PID[3:0] of the current or last packet.
//   o_lastData(_nBytes)     : payload of the last data packet (byte0 in [7:0]).
//   o_lastAddr / o_lastEndp : fields of the last good OUT/IN/SETUP token.
//   o_pidOkay / o_tokenOkay / o_dataOkay : packet checks, valid after o_eop.
module usb_fs_packet_receiver #(
   parameter int AS_HOST_NOT_DEV = 0,
   parameter int MAX_PKT         = 8
) (
   input  logic                       i_clk_48MHz,
   input  logic                       i_rst,
   input  logic                       i_dp,
   input  logic                       i_dn,
   output logic                       o_strobe_12MHz,
   output logic                       o_sop,
   output logic                       o_eop,
   output logic                       o_inflight,
   output logic [3:0]                 o_pid,
   output logic [8*MAX_PKT-1:0]       o_lastData,
   output logic [$clog2(MAX_PKT):0]   o_lastData_nBytes,
   output logic [6:0]                 o_lastAddr,
   output logic [3:0]                 o_lastEndp,
   output logic                       o_pidOkay,
   output logic                       o_tokenOkay,
   output logic                       o_dataOkay
);
   localparam int NBW = $clog2(MAX_PKT) + 1;
   localparam int BCW = $clog2(MAX_PKT + 3) + 1;   // byte count incl. PID, saturating

   typedef enum logic [1:0] {LS_SE0, LS_J, LS_K} line_t;
   typedef enum logic [1:0] {S_IDLE, S_PKT, S_SE0A, S_SE0B} state_t;

   logic dp_s, dn_s;
`ifdef USBFS_RX_INSYNC_EN
   logic [1:0] dp_sync, dn_sync;
   // The synchronizer resets to J so that reset does not look like SE0.
   always_ff @(posedge i_clk_48MHz) begin
      if (i_rst) begin
         dp_sync <= 2'b11;
         dn_sync <= 2'b00;
      end else begin
         dp_sync <= {dp_sync[0], i_dp};
         dn_sync <= {dn_sync[0], i_dn};
      end
   end
   assign dp_s = dp_sync[1];
   assign dn_s = dn_sync[1];
`else
   assign dp_s = i_dp;
   assign dn_s = i_dn;
`endif

   line_t  ls, prev_ls, last_smp;
   state_t state_q, state_d;
   logic [1:0]  phase;
   logic [6:0]  se0_cyc;
   logic [2:0]  zcnt, ones, bit_cnt;
   logic [7:0]  byte_q, pid_byte;
   logic [BCW-1:0] byte_cnt, pay_n;
   logic [4:0]  crc5;
   logic [15:0] crc16;
   logic        stuff_err, ovf;
   logic [MAX_PKT-1:0][7:0] buf_q;   // payload bytes only; CRC bytes are not kept
   logic        strobe, nrzi, sop, eop, bus_rst;
   logic        is_tok, is_dat, pid_good, tok_good, dat_len;
   logic [7:0]  byte_nx;
   logic [4:0]  crc5_nx;
   logic [15:0] crc16_nx;
   logic [8*MAX_PKT-1:0] ld_nx;

   // (1,1) decodes as SE0.
   always_comb begin
      ls = LS_SE0;
      if (dp_s && !dn_s)      ls = LS_J;
      else if (!dp_s && dn_s) ls = LS_K;
   end

   assign strobe   = (phase == 2'd2);
   assign nrzi     = (ls == last_smp);
   assign bus_rst  = (ls == LS_SE0) && (se0_cyc >= 7'd120) && (state_q != S_IDLE);
   assign byte_nx  = {nrzi, byte_q[7:1]};
   assign crc5_nx  = {crc5[3:0], 1'b0} ^ ({5{crc5[4] ^ nrzi}} & 5'b00101);
   assign crc16_nx = {crc16[14:0], 1'b0} ^ ({16{crc16[15] ^ nrzi}} & 16'h8005);

   always_comb begin
      state_d = state_q;
      sop     = 1'b0;
      eop     = 1'b0;
      if (bus_rst) begin
         state_d = S_IDLE;
      end else if (strobe) begin
         case (state_q)
            // seven NRZI zeros then a one (the closing KK of SYNC)
            S_IDLE: if (ls != LS_SE0 && nrzi && zcnt == 3'd7) begin
               sop     = 1'b1;
               state_d = S_PKT;
            end
            S_PKT:  if (ls == LS_SE0) state_d = S_SE0A;
            S_SE0A: state_d = (ls == LS_SE0) ? S_SE0B : S_IDLE;
            S_SE0B: if (ls == LS_J) begin
               eop     = 1'b1;
               state_d = S_IDLE;
            end else if (ls == LS_K) begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk_48MHz) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign o_strobe_12MHz = strobe;
   assign o_sop          = sop;
   assign o_eop          = eop;
   assign o_inflight     = (state_q != S_IDLE) || sop;

   // End-of-packet classification
   assign is_tok   = (pid_byte[1:0] == 2'b01);
   assign is_dat   = (pid_byte[1:0] == 2'b11);
   assign pid_good = (byte_cnt != '0) && (pid_byte[7:4] == ~pid_byte[3:0]) && !stuff_err;
   assign tok_good = pid_good && (byte_cnt == BCW'(3)) && (bit_cnt == 3'd0) && (crc5 == 5'b01100);
   assign dat_len  = (byte_cnt >= BCW'(3)) && !ovf && (bit_cnt == 3'd0);

   always_comb begin
      pay_n = '0;
      if (byte_cnt >= BCW'(3)) begin
         pay_n = byte_cnt - BCW'(3);
         if (pay_n > BCW'(MAX_PKT)) pay_n = BCW'(MAX_PKT);
      end
      ld_nx = '0;
      for (int i = 0; i < MAX_PKT; i++)
         ld_nx[i*8 +: 8] = (BCW'(i) < pay_n) ? buf_q[i] : 8'h00;
   end

   always_ff @(posedge i_clk_48MHz) begin
      if (i_rst) begin
         prev_ls   <= LS_J;
         last_smp  <= LS_J;
         phase     <= '0;
         se0_cyc   <= '0;
         zcnt      <= '0;
         ones      <= '0;
         bit_cnt   <= '0;
         byte_q    <= '0;
         pid_byte  <= '0;
         byte_cnt  <= '0;
         crc5      <= '0;
         crc16     <= '0;
         stuff_err <= 1'b0;
         ovf       <= 1'b0;
         buf_q     <= '0;
         o_pid             <= '0;
         o_lastData        <= '0;
         o_lastData_nBytes <= '0;
         o_lastAddr        <= '0;
         o_lastEndp        <= '0;
         o_pidOkay         <= 1'b0;
         o_tokenOkay       <= 1'b0;
         o_dataOkay        <= 1'b0;
      end else begin
         // Bit clock recovery: re-centre on every edge of the line state.
         prev_ls <= ls;
         phase   <= (ls != prev_ls) ? 2'd0 : phase + 2'd1;
         se0_cyc <= (ls != LS_SE0) ? 7'd0 : ((se0_cyc == 7'h7f) ? se0_cyc : se0_cyc + 7'd1);

         if (strobe) begin
            last_smp <= ls;
            if (state_q == S_IDLE && ls != LS_SE0 && !nrzi)
               zcnt <= (zcnt == 3'd7) ? zcnt : zcnt + 3'd1;
            else
               zcnt <= '0;
         end

         if (sop) begin
            ones        <= 3'd1;   // the SYNC's final one counts toward stuffing
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            crc5        <= 5'h1f;
            crc16       <= 16'hffff;
            stuff_err   <= 1'b0;
            ovf         <= 1'b0;
            o_pidOkay   <= 1'b0;
            o_tokenOkay <= 1'b0;
            o_dataOkay  <= 1'b0;
         end else if (strobe && state_q == S_PKT && ls != LS_SE0) begin
            if (ones == 3'd6) begin
               // stuffed bit: dropped, must be a zero
               ones <= '0;
               if (nrzi) stuff_err <= 1'b1;
            end else begin
               ones    <= nrzi ? ones + 3'd1 : 3'd0;
               byte_q  <= byte_nx;
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_cnt != '0) begin
                  crc5  <= crc5_nx;
                  crc16 <= crc16_nx;
               end
               if (bit_cnt == 3'd7) begin
                  if (byte_cnt == '0) begin
                     pid_byte <= byte_nx;
                     o_pid    <= byte_nx[3:0];
                  end
                  for (int i = 0; i < MAX_PKT; i++)
                     if (byte_cnt == BCW'(i + 1)) buf_q[i] <= byte_nx;
                  if (byte_cnt > BCW'(MAX_PKT + 2)) ovf <= 1'b1;
                  if (byte_cnt != '1) byte_cnt <= byte_cnt + BCW'(1);
               end
            end
         end

         if (eop) begin
            // handshakes and other PIDs must carry nothing after the PID
            o_pidOkay   <= pid_good && (is_tok || is_dat ||
                                        (byte_cnt == BCW'(1) && bit_cnt == 3'd0));
            o_tokenOkay <= is_tok && tok_good && (AS_HOST_NOT_DEV == 0);
            o_dataOkay  <= is_dat && pid_good && dat_len && (crc16 == 16'h800D);
            if (is_tok && tok_good && pid_byte[3:0] != 4'b0101) begin
               o_lastAddr <= buf_q[0][6:0];
               o_lastEndp <= {buf_q[1][2:0], buf_q[0][7]};
            end
            if (is_dat) begin
               o_lastData        <= ld_nx;
               o_lastData_nBytes <= NBW'(pay_n);
            end
         end
      end
   end
endmodule

// File: tb/tb_usb_fs_packet_receiver.sv
// Directed bench for usb_fs_packet_receiver: a bit-accurate NRZI/stuffing
// sender drives packets, and the results are compared with hand-derived values.
module tb_usb_fs_packet_receiver;
   localparam int MAX_PKT = 8;
   localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

   logic clk = 1'b0;
   logic rst, dp, dn;
   logic strobe, sop, eop, inflight, pid_ok, tok_ok, dat_ok;
   logic [3:0] pid, endp;
   logic [6:0] addr;
   logic [8*MAX_PKT-1:0] ldata;
   logic [$clog2(MAX_PKT):0] nbytes;

   always #5 clk = ~clk;

   usb_fs_packet_receiver #(.AS_HOST_NOT_DEV(0), .MAX_PKT(MAX_PKT)) dut (
      .i_clk_48MHz(clk), .i_rst(rst), .i_dp(dp), .i_dn(dn),
      .o_strobe_12MHz(strobe), .o_sop(sop), .o_eop(eop), .o_inflight(inflight),
      .o_pid(pid), .o_lastData(ldata), .o_lastData_nBytes(nbytes),
      .o_lastAddr(addr), .o_lastEndp(endp),
      .o_pidOkay(pid_ok), .o_tokenOkay(tok_ok), .o_dataOkay(dat_ok)
   );

   int total = 0, bad = 0;
   int n_sop = 0, n_eop = 0, n_stb = 0;
   logic [7:0] pk [16];
   logic lvl;

   always @(negedge clk) begin
      if (sop)    n_sop++;
      if (eop)    n_eop++;
      if (strobe) n_stb++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_ls(input logic [1:0] v);
      {dp, dn} = v;
      cyc(4);
   endtask

   task automatic tx_bit(input logic b);
      if (!b) lvl = ~lvl;
      drive_ls(lvl ? LJ : LK);
   endtask

   task automatic idle(input int bits);
      lvl = 1'b1;
      for (int i = 0; i < bits; i++) drive_ls(LJ);
   endtask

   // SYNC plus n bytes of pk, stuffed; viol makes the first stuff bit a one.
   task automatic send_body(input int n, input bit viol);
      int ones;
      bit vdone;
      lvl = 1'b1;
      for (int i = 0; i < 7; i++) tx_bit(1'b0);
      tx_bit(1'b1);
      ones  = 1;
      vdone = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 8; j++) begin
            tx_bit(pk[i][j]);
            ones = pk[i][j] ? ones + 1 : 0;
            if (ones == 6) begin
               if (viol && !vdone) begin
                  tx_bit(1'b1);
                  vdone = 1;
               end else begin
                  tx_bit(1'b0);
               end
               ones = 0;
            end
         end
   endtask

   task automatic send_pkt(input int n, input bit viol);
      send_body(n, viol);
      drive_ls(LSE0);
      drive_ls(LSE0);
      drive_ls(LJ);
      idle(2);
   endtask

   // CRC-16/USB over pk[first +: cnt], sent low byte first
   function automatic logic [15:0] crc16_of(input int first, input int cnt);
      logic [15:0] c;
      c = 16'hffff;
      for (int i = first; i < first + cnt; i++) begin
         c = c ^ {8'h00, pk[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'ha001) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic [4:0] crc5_of(input logic [10:0] v);
      logic [4:0] c;
      c = 5'h1f;
      for (int i = 0; i < 11; i++) c = (c[0] ^ v[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
      return ~c;
   endfunction

   task automatic set_token(input logic [7:0] p, input logic [10:0] v);
      logic [15:0] w;
      w = {crc5_of(v), v};
      pk[0] = p;
      pk[1] = w[7:0];
      pk[2] = w[15:8];
   endtask

   int s0, e0;
   logic [15:0] c16;

   initial begin
      rst = 1'b1;
      {dp, dn} = LJ;
      cyc(3);
      chk("rst_pid", pid, 0);
      chk("rst_flags", {pid_ok, tok_ok, dat_ok, inflight}, 0);
      chk("rst_data", ldata, 0);
      chk("rst_nbytes", nbytes, 0);
      chk("rst_addr", {endp, addr}, 0);
      rst = 1'b0;

      // idle bus: free-running strobe, no SYNC
      cyc(8);
      s0 = n_stb;
      e0 = n_sop;
      cyc(100);
      chk("idle_strobes", n_stb - s0, 25);
      chk("idle_no_sop", n_sop - e0, 0);

      // SETUP addr 0 endp 0
      pk[0] = 8'h2D; pk[1] = 8'h00; pk[2] = 8'h10;
      s0 = n_sop; e0 = n_eop;
      send_pkt(3, 0);
      chk("setup_sop", n_sop - s0, 1);
      chk("setup_eop", n_eop - e0, 1);
      chk("setup_pid", pid, 4'hD);
      chk("setup_ok", {pid_ok, tok_ok}, 2'b11);
      chk("setup_addr", {endp, addr}, 0);
      chk("setup_inflight", inflight, 0);

      // OUT addr 0x15 endp 0xE
      set_token(8'hE1, {4'hE, 7'h15});
      send_pkt(3, 0);
      chk("out_pid", pid, 4'h1);
      chk("out_tok", tok_ok, 1);
      chk("out_addr", addr, 7'h15);
      chk("out_endp", endp, 4'hE);

      // SOF frame 0x123 leaves address/endpoint alone
      set_token(8'hA5, 11'h123);
      send_pkt(3, 0);
      chk("sof_tok", {pid_ok, tok_ok}, 2'b11);
      chk("sof_keep", {endp, addr}, {4'hE, 7'h15});

      // DATA0 GET_DESCRIPTOR
      pk[0] = 8'hC3; pk[1] = 8'h80; pk[2] = 8'h06; pk[3] = 8'h00; pk[4] = 8'h01;
      pk[5] = 8'h00; pk[6] = 8'h00; pk[7] = 8'h40; pk[8] = 8'h00;
      pk[9] = 8'hDD; pk[10] = 8'h94;
      send_pkt(11, 0);
      chk("d0_pid", pid, 4'h3);
      chk("d0_flags", {pid_ok, tok_ok, dat_ok}, 3'b101);
      chk("d0_n", nbytes, 8);
      chk("d0_data", ldata, 64'h0040_0000_0100_0680);

      // empty DATA1
      pk[0] = 8'h4B; pk[1] = 8'h00; pk[2] = 8'h00;
      send_pkt(3, 0);
      chk("d1_ok", dat_ok, 1);
      chk("d1_n", nbytes, 0);
      chk("d1_data", ldata, 0);

      // ACK
      pk[0] = 8'hD2;
      send_pkt(1, 0);
      chk("ack_pid", pid, 4'h2);
      chk("ack_ok", {pid_ok, dat_ok}, 2'b10);

      // SETUP with a CRC bit flipped
      pk[0] = 8'h2D; pk[1] = 8'h00; pk[2] = 8'h18;
      send_pkt(3, 0);
      chk("badcrc_tok", tok_ok, 0);
      chk("badcrc_pid", pid_ok, 1);

      // broken PID check
      pk[0] = 8'h2E;
      send_pkt(1, 0);
      chk("badpid_pid", pid, 4'hE);
      chk("badpid_ok", pid_ok, 0);

      // all-ones payload forces stuffing
      pk[0] = 8'hC3;
      for (int i = 1; i <= 4; i++) pk[i] = 8'hFF;
      c16 = crc16_of(1, 4);
      pk[5] = c16[7:0]; pk[6] = c16[15:8];
      send_pkt(7, 0);
      chk("ff_ok", dat_ok, 1);
      chk("ff_n", nbytes, 4);
      chk("ff_data", ldata, 64'h0000_0000_FFFF_FFFF);
      send_pkt(7, 1);
      chk("stuffviol_ok", {pid_ok, dat_ok}, 2'b00);

      // nine payload bytes: one too many
      pk[0] = 8'hC3;
      for (int i = 1; i <= 9; i++) pk[i] = 8'(i);
      c16 = crc16_of(1, 9);
      pk[10] = c16[7:0]; pk[11] = c16[15:8];
      send_pkt(12, 0);
      chk("ovf_ok", dat_ok, 0);

      // long SE0 mid-packet: bus reset, no EOP
      pk[0] = 8'hC3; pk[1] = 8'h80;
      e0 = n_eop;
      send_body(2, 0);
      {dp, dn} = LSE0;
      cyc(130);
      chk("busrst_inflight", inflight, 0);
      idle(10);
      chk("busrst_no_eop", n_eop - e0, 0);
      chk("busrst_pid_held", pid, 4'h3);

      // reset in the middle of a DATA0
      pk[0] = 8'hC3; pk[1] = 8'h80; pk[2] = 8'h06;
      e0 = n_eop;
      send_body(3, 0);
      chk("midrst_inflight_before", inflight, 1);
      rst = 1'b1;
      cyc(1);
      chk("midrst_inflight_after", inflight, 0);
      rst = 1'b0;
      idle(15);
      chk("midrst_no_eop", n_eop - e0, 0);
      chk("midrst_cleared", {pid, pid_ok, dat_ok, nbytes}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
